perf_monitor: RTL and testbench

- Synthesizable performance-counter block for the out-of-order core.
- Watches the scheduler issue stream, the instruction-queue occupancy vector and the inner/outer hazard vectors; accumulates cycle, instruction, no-op, queue-busy and hazard statistics.
- Software or a bench reads results through a registered index/data port instead of computing them in simulation.
- Generalised in queue depth and counter width; adds saturation, run control, end-of-program detection and per-slot counters.

---
 rtl/perf_monitor_pkg.sv | 32 +++
 rtl/perf_monitor_sat_counter.sv | 30 +++
 rtl/perf_monitor.sv | 175 +++++++++++++++++
 tb/tb_perf_monitor.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/perf_monitor_pkg.sv
// Shared definitions for perf_monitor: FSM encoding, read-port index map and popcount helper.
package perf_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SEL_CYCLES    = 0;
    localparam int SEL_INSTR     = 1;
    localparam int SEL_NOOP      = 2;
    localparam int SEL_QBUSY     = 3;
    localparam int SEL_INNER     = 4;
    localparam int SEL_OUTER     = 5;
    localparam int SEL_STATUS    = 6;
    localparam int SEL_DEPTH     = 7;
    localparam int SEL_SLOT_BASE = 8;

    // Queue vectors are zero-extended to this width before counting.
    localparam int POP_MAX_WIDTH = 32;

    function automatic logic [5:0] popcount(input logic [POP_MAX_WIDTH-1:0] vec);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < POP_MAX_WIDTH; i++) begin
            n = n + 6'(vec[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/perf_monitor_sat_counter.sv
// Saturating accumulator: holds all-ones instead of wrapping and flags the attempted overflow.
module sat_counter #(
    parameter int CNT_WIDTH = 32,
    parameter int INC_WIDTH = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 enable,
    input  logic [INC_WIDTH-1:0] increment,
    output logic [CNT_WIDTH-1:0] value,
    output logic                 saturated
);

    logic [CNT_WIDTH:0] sum;

    assign sum       = {1'b0, value} + (CNT_WIDTH+1)'(increment);
    assign saturated = enable && !clear && sum[CNT_WIDTH];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (enable) begin
            value <= sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/perf_monitor.sv
// Performance counters for the scheduler issue stream and instruction queue, read via rd_sel/rd_data.
// Per-slot hazard counters are built only when PERF_PER_SLOT_EN is defined.
module perf_monitor #(
    parameter int          QUEUE_DEPTH = 4,
    parameter int          CNT_WIDTH   = 32,
    parameter int          PC_WIDTH    = 20,
    parameter logic [4:0]  DONE_REG    = 5'd9,
    parameter int          SEL_WIDTH   = 5
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   clear,
    input  logic                   scheduler_valid,
    input  logic [PC_WIDTH-1:0]    scheduled_instruction_PC,
    input  logic [QUEUE_DEPTH-1:0] queue_in_use,
    input  logic [QUEUE_DEPTH-1:0] inner_hazard,
    input  logic [QUEUE_DEPTH-1:0] outer_hazard,
    input  logic                   wb_valid,
    input  logic [4:0]             register_writeback,
    input  logic [SEL_WIDTH-1:0]   rd_sel,
    output logic [CNT_WIDTH-1:0]   rd_data,
    output logic                   running,
    output logic                   done,
    output logic                   overflow
);
    import perf_monitor_pkg::*;

    // state | meaning
    // IDLE  | counters hold, waiting for start
    // RUN   | counters accumulate every cycle
    // DONE  | end-of-program writeback seen, counters frozen until clear

    localparam int INC_WIDTH = $clog2(QUEUE_DEPTH + 1);
    localparam int NUM_MAIN  = 6;

    state_t                 state;
    logic                   count_en;
    logic                   done_hit;
    logic                   any_sat;
    logic [INC_WIDTH-1:0]   inc [NUM_MAIN];
    logic [CNT_WIDTH-1:0]   cnt [NUM_MAIN];
    logic [NUM_MAIN-1:0]    sat_main;
    logic [CNT_WIDTH-1:0]   rd_next;
    int                     sel_i;

    assign count_en = (state == RUN) && !clear;
    assign done_hit = wb_valid && (register_writeback == DONE_REG);

    always_comb begin
        inc[SEL_CYCLES] = INC_WIDTH'(1'b1);
        inc[SEL_INSTR]  = INC_WIDTH'(scheduler_valid && (scheduled_instruction_PC != '0));
        inc[SEL_NOOP]   = INC_WIDTH'(scheduler_valid && (scheduled_instruction_PC == '0));
        inc[SEL_QBUSY]  = INC_WIDTH'(|queue_in_use);
        inc[SEL_INNER]  = INC_WIDTH'(popcount(POP_MAX_WIDTH'(inner_hazard & queue_in_use)));
        inc[SEL_OUTER]  = INC_WIDTH'(popcount(POP_MAX_WIDTH'(outer_hazard & queue_in_use)));
    end

    for (genvar g = 0; g < NUM_MAIN; g++) begin : g_main
        sat_counter #(
            .CNT_WIDTH (CNT_WIDTH),
            .INC_WIDTH (INC_WIDTH)
        ) u_cnt (
            .clock     (clock),
            .reset     (reset),
            .clear     (clear),
            .enable    (count_en),
            .increment (inc[g]),
            .value     (cnt[g]),
            .saturated (sat_main[g])
        );
    end

`ifdef PERF_PER_SLOT_EN
    // Slots 0..QUEUE_DEPTH-1 are inner hazards, the next QUEUE_DEPTH are outer hazards.
    logic [CNT_WIDTH-1:0]     slot_cnt [2*QUEUE_DEPTH];
    logic [2*QUEUE_DEPTH-1:0] sat_slot;
    logic [2*QUEUE_DEPTH-1:0] slot_hit;

    assign slot_hit = {outer_hazard & queue_in_use, inner_hazard & queue_in_use};

    for (genvar g = 0; g < 2*QUEUE_DEPTH; g++) begin : g_slot
        sat_counter #(
            .CNT_WIDTH (CNT_WIDTH),
            .INC_WIDTH (1)
        ) u_slot (
            .clock     (clock),
            .reset     (reset),
            .clear     (clear),
            .enable    (count_en),
            .increment (slot_hit[g]),
            .value     (slot_cnt[g]),
            .saturated (sat_slot[g])
        );
    end

    assign any_sat = (|sat_main) || (|sat_slot);
`else
    assign any_sat = |sat_main;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            running  <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else if (clear) begin
            state    <= IDLE;
            running  <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (any_sat) begin
                overflow <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    if (done_hit) begin
                        state   <= DONE;
                        running <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        rd_next = '0;
        sel_i   = int'(rd_sel);
        case (sel_i)
            SEL_CYCLES: rd_next = cnt[SEL_CYCLES];
            SEL_INSTR:  rd_next = cnt[SEL_INSTR];
            SEL_NOOP:   rd_next = cnt[SEL_NOOP];
            SEL_QBUSY:  rd_next = cnt[SEL_QBUSY];
            SEL_INNER:  rd_next = cnt[SEL_INNER];
            SEL_OUTER:  rd_next = cnt[SEL_OUTER];
            SEL_STATUS: rd_next = CNT_WIDTH'({overflow, done, running});
            SEL_DEPTH:  rd_next = CNT_WIDTH'(QUEUE_DEPTH);
            default: begin
`ifdef PERF_PER_SLOT_EN
                for (int i = 0; i < 2*QUEUE_DEPTH; i++) begin
                    if (sel_i == SEL_SLOT_BASE + i) begin
                        rd_next = slot_cnt[i];
                    end
                end
`endif
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= rd_next;
        end
    end

endmodule

// File: tb/tb_perf_monitor.sv
// Bench for perf_monitor: a 32-bit and a 4-bit instance share stimulus and are checked every cycle
// against a behavioural model; directed sequences pin the model with hand-computed values.
module tb_perf_monitor;

    localparam int QD      = 4;
    localparam int PCW     = 20;
    localparam int W_BIG   = 32;
    localparam int W_SMALL = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic             start;
    logic             clear;
    logic             scheduler_valid;
    logic [PCW-1:0]   pc;
    logic [QD-1:0]    queue_in_use;
    logic [QD-1:0]    inner_hazard;
    logic [QD-1:0]    outer_hazard;
    logic             wb_valid;
    logic [4:0]       register_writeback;
    logic [4:0]       rd_sel;

    logic [W_BIG-1:0]   rd_big;
    logic [W_SMALL-1:0] rd_small;
    logic run_big, done_big, ovf_big;
    logic run_small, done_small, ovf_small;

    perf_monitor #(
        .QUEUE_DEPTH (QD), .CNT_WIDTH (W_BIG), .PC_WIDTH (PCW), .DONE_REG (5'd9), .SEL_WIDTH (5)
    ) dut_big (
        .clock (clock), .reset (reset), .start (start), .clear (clear),
        .scheduler_valid (scheduler_valid), .scheduled_instruction_PC (pc),
        .queue_in_use (queue_in_use), .inner_hazard (inner_hazard), .outer_hazard (outer_hazard),
        .wb_valid (wb_valid), .register_writeback (register_writeback), .rd_sel (rd_sel),
        .rd_data (rd_big), .running (run_big), .done (done_big), .overflow (ovf_big)
    );

    perf_monitor #(
        .QUEUE_DEPTH (QD), .CNT_WIDTH (W_SMALL), .PC_WIDTH (PCW), .DONE_REG (5'd9), .SEL_WIDTH (5)
    ) dut_small (
        .clock (clock), .reset (reset), .start (start), .clear (clear),
        .scheduler_valid (scheduler_valid), .scheduled_instruction_PC (pc),
        .queue_in_use (queue_in_use), .inner_hazard (inner_hazard), .outer_hazard (outer_hazard),
        .wb_valid (wb_valid), .register_writeback (register_writeback), .rd_sel (rd_sel),
        .rd_data (rd_small), .running (run_small), .done (done_small), .overflow (ovf_small)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: 0 = idle, 1 = run, 2 = done; index k = 0 big instance, k = 1 small instance.
    int     m_state;
    longint m_cnt  [2][6];
    longint m_slot [2][2*QD];
    bit     m_ovf  [2];
    longint m_rd   [2];
    longint m_max  [2];

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic longint sat_add(int k, longint v, longint inc);
        if (v + inc > m_max[k]) begin
            m_ovf[k] = 1'b1;
            return m_max[k];
        end
        return v + inc;
    endfunction

    function automatic longint model_read(int k, int sel);
        if (sel <= 5) return m_cnt[k][sel];
        if (sel == 6) return (m_ovf[k] ? 4 : 0) + (m_state == 2 ? 2 : 0) + (m_state == 1 ? 1 : 0);
        if (sel == 7) return QD;
`ifdef PERF_PER_SLOT_EN
        if (sel >= 8 && sel < 8 + 2*QD) return m_slot[k][sel-8];
`endif
        return 0;
    endfunction

    task automatic model_zero();
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 6; j++) m_cnt[k][j] = 0;
            for (int j = 0; j < 2*QD; j++) m_slot[k][j] = 0;
            m_ovf[k] = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) m_rd[k] = model_read(k, int'(rd_sel));
        if (clear) begin
            model_zero();
            m_state = 0;
        end else if (m_state == 1) begin
            for (int k = 0; k < 2; k++) begin
                m_cnt[k][0] = sat_add(k, m_cnt[k][0], 1);
                m_cnt[k][1] = sat_add(k, m_cnt[k][1], (scheduler_valid && pc != 0) ? 1 : 0);
                m_cnt[k][2] = sat_add(k, m_cnt[k][2], (scheduler_valid && pc == 0) ? 1 : 0);
                m_cnt[k][3] = sat_add(k, m_cnt[k][3], (queue_in_use != 0) ? 1 : 0);
                m_cnt[k][4] = sat_add(k, m_cnt[k][4], $countones(inner_hazard & queue_in_use));
                m_cnt[k][5] = sat_add(k, m_cnt[k][5], $countones(outer_hazard & queue_in_use));
`ifdef PERF_PER_SLOT_EN
                for (int i = 0; i < QD; i++) begin
                    m_slot[k][i]    = sat_add(k, m_slot[k][i], (inner_hazard[i] && queue_in_use[i]) ? 1 : 0);
                    m_slot[k][QD+i] = sat_add(k, m_slot[k][QD+i], (outer_hazard[i] && queue_in_use[i]) ? 1 : 0);
                end
`endif
            end
            if (wb_valid && register_writeback == 5'd9) m_state = 2;
        end else if (m_state == 0 && start) begin
            m_state = 1;
        end
    endtask

    task automatic compare_all();
        check("big.running",    run_big,    m_state == 1);
        check("big.done",       done_big,   m_state == 2);
        check("big.overflow",   ovf_big,    m_ovf[0]);
        check("big.rd_data",    rd_big,     m_rd[0]);
        check("small.running",  run_small,  m_state == 1);
        check("small.done",     done_small, m_state == 2);
        check("small.overflow", ovf_small,  m_ovf[1]);
        check("small.rd_data",  rd_small,   m_rd[1]);
    endtask

    task automatic cycle();
        model_step();
        @(negedge clock);
        compare_all();
    endtask

    task automatic quiet_inputs();
        start = 0; clear = 0; scheduler_valid = 0; pc = '0;
        queue_in_use = '0; inner_hazard = '0; outer_hazard = '0;
        wb_valid = 0; register_writeback = '0; rd_sel = '0;
    endtask

    task automatic model_reset();
        model_zero();
        m_state = 0;
        m_rd[0] = 0;
        m_rd[1] = 0;
    endtask

    initial begin
        m_max[0] = 64'hFFFF_FFFF;
        m_max[1] = 15;
        model_reset();
        reset = 1'b0;
        quiet_inputs();
        repeat (2) @(negedge clock);
        compare_all();
        reset = 1'b1;

        // Directed run: alternating PCs, queue hazards, saturation of the small instance, end of program.
        start = 1;
        cycle();
        start = 0;
        check("lit.running_after_start", run_big, 1);
        rd_sel = 5'd6;
        for (int i = 0; i < 10; i++) begin
            scheduler_valid = 1;
            pc = (i % 2 == 0) ? 20'h00010 : 20'h00000;
            cycle();
        end
        scheduler_valid = 0; pc = '0;
        queue_in_use = 4'b0111; inner_hazard = 4'b1101; outer_hazard = 4'b0010;
        repeat (3) cycle();
        queue_in_use = '0; inner_hazard = '0; outer_hazard = '0;
        for (int i = 14; i <= 20; i++) begin
            wb_valid = (i == 20);
            register_writeback = (i == 20) ? 5'd9 : 5'd3;
            cycle();
            if (i == 15) check("lit.small_ovf_at15", ovf_small, 0);
            if (i == 16) begin
                check("lit.small_ovf_at16", ovf_small, 1);
                check("lit.small_status_at16", rd_small, 1);
            end
            if (i == 17) begin
                check("lit.small_status_run_ovf", rd_small, 5);
                check("lit.big_status_run", rd_big, 1);
            end
        end
        wb_valid = 0; register_writeback = '0;
        check("lit.done_set", done_big, 1);
        check("lit.running_clr", run_big, 0);

        rd_sel = 5'd0; cycle();
        check("lit.cycle_cnt", rd_big, 20);
        check("lit.small_cycle_cnt", rd_small, 15);
        rd_sel = 5'd1; cycle(); check("lit.instr_cnt", rd_big, 5);
        rd_sel = 5'd2; cycle(); check("lit.noop_cnt", rd_big, 5);
        rd_sel = 5'd3; cycle(); check("lit.qbusy_cnt", rd_big, 3);
        rd_sel = 5'd4; cycle(); check("lit.inner_sum", rd_big, 6);
        rd_sel = 5'd5; cycle(); check("lit.outer_sum", rd_big, 3);
        rd_sel = 5'd6; cycle();
        check("lit.status_done", rd_big, 2);
        check("lit.small_status_done", rd_small, 6);
        rd_sel = 5'd7; cycle(); check("lit.depth", rd_big, 4);
        rd_sel = 5'd31; cycle(); check("lit.idx31", rd_big, 0);

        start = 1; rd_sel = 5'd0; cycle(); start = 0;
        check("lit.start_in_done", done_big, 1);
        repeat (2) cycle();
        check("lit.frozen_cycle_cnt", rd_big, 20);

        clear = 1; cycle(); clear = 0;
        check("lit.clear_done", done_big, 0);
        check("lit.clear_ovf", ovf_small, 0);
        cycle();
        check("lit.clear_cycle_cnt", rd_big, 0);
        clear = 1; start = 1; cycle(); clear = 0; start = 0;
        check("lit.clear_beats_start", run_big, 0);

        // Asynchronous reset in the middle of a run.
        start = 1; cycle(); start = 0;
        rd_sel = 5'd0;
        for (int i = 0; i < 7; i++) begin
            scheduler_valid = 1; pc = PCW'(i); queue_in_use = 4'b1111; inner_hazard = 4'b1010;
            cycle();
        end
        check("lit.pre_reset_rd", rd_big, 6);
        reset = 1'b0;
        #1;
        check("lit.reset_rd", rd_big, 0);
        check("lit.reset_running", run_big, 0);
        check("lit.reset_small_ovf", ovf_small, 0);
        check("lit.reset_small_rd", rd_small, 0);
        model_reset();
        quiet_inputs();
        @(negedge clock);
        reset = 1'b1;
        compare_all();

`ifdef PERF_PER_SLOT_EN
        start = 1; cycle(); start = 0;
        queue_in_use = 4'b0100; inner_hazard = 4'b0100;
        repeat (4) cycle();
        queue_in_use = '0; inner_hazard = '0;
        wb_valid = 1; register_writeback = 5'd9; rd_sel = 5'd10;
        cycle();
        wb_valid = 0;
        check("lit.slot2_inner", rd_big, 4);
        clear = 1; cycle(); clear = 0;
`endif

        // Randomised traffic.
        for (int n = 0; n < 3000; n++) begin
            start = ($urandom % 8 == 0);
            clear = ($urandom % 48 == 0);
            scheduler_valid = $urandom % 2;
            pc = ($urandom % 3 == 0) ? '0 : PCW'($urandom);
            queue_in_use = QD'($urandom);
            inner_hazard = QD'($urandom);
            outer_hazard = QD'($urandom);
            wb_valid = ($urandom % 4 == 0);
            register_writeback = ($urandom % 8 == 0) ? 5'd9 : 5'($urandom);
            rd_sel = ($urandom % 4 == 0) ? 5'($urandom) : 5'($urandom_range(0, 8));
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
